key_entry_display: RTL
======================

# key_entry_display

Downstream consumer of the 4x4 matrix-keypad scanner. Turns each key press into an edit of an 8-digit hex entry buffer (shift-in, backspace, clear) and drives the 8-digit multiplexed seven-segment display. It replaces the scanner's single static digit with a scanned multi-digit readout, and exposes the entered word to later project stages.

## Interface
Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (2 ms at 50 MHz); legal range 2..2^20.
- SETTLE_CYC, 2097152: clk cycles from synchronized key_flag rise to key_val sampling; legal range 1..2^22. Covers two key_clk periods of the scanner.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- key_flag  in  1  scanner key-pressed level, key_clk domain, asynchronous to clk.
- key_val  in  4  scanner key code, quasi-static; valid SETTLE_CYC after flag rise.
- seg_an  out  8  digit anodes, active-low, bit i = digit i (digit 0 rightmost).
- seg_out  out  8  segment cathodes, active-low; bit7 = dp, bits6..0 = g..a.
- entry_word  out  32  buffer, nibble i = digit i.
- entry_count  out  4  number of entered digits, 0..8.
- entry_strobe  out  1  one-cycle pulse on every buffer change.

## Operation
- key_flag passes through a 2-FF synchronizer, then a rising-edge detector on the synced level.
- Capture FSM states:
  - IDLE: on rising edge, load settle counter with SETTLE_CYC-1 and go to SETTLE.
  - SETTLE: count down. If the synced flag drops, return to IDLE with no action. At 0, sample key_val and go to EXEC.
  - EXEC: apply the command for one cycle, then go to HOLD.
  - HOLD: wait for synced flag low, then go to IDLE. Exactly one command per press; no auto-repeat.
- Commands:
  - 0x0..0xD, digit: if count<8, word <= {word[27:0], key} and count+1. If count==8, ignore; no strobe.
  - 0xE, backspace: if count>0, word <= {4'h0, word[31:4]} and count-1. Otherwise no-op, no strobe.
  - 0xF, clear: word <= 0, count <= 0. Strobe always fires.
- Display scan:
  - Divider counts 0..SCAN_DIV-1. At terminal count, digit index idx increments mod 8 (7 wraps to 0).
  - Glyphs (active-low, dp off), hex: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - Digit idx is shown when enabled (see Configuration): seg_an = ~(8'b1 << idx), seg_out = glyph(word nibble idx).
  - A blanked digit gives seg_an = 8'hFF, seg_out = 8'hFF.
- Key capture and display scan are independent. A command landing on a scan tick is shown from the next registered update.

## Timing
- Reset values: seg_an=FF, seg_out=FF, entry_word=0, entry_count=0, entry_strobe=0, FSM=IDLE, idx=0, divider=0, synchronizer=0.
- rst mid-press forces IDLE. If key_flag is still high after release of rst, the synced edge detector sees a fresh rise and the press is processed once.
- Latency, key_flag rise to entry_word/entry_count/entry_strobe update: 2 sync + 1 edge + SETTLE_CYC + 1 cycles.
- entry_strobe is high in the same cycle the new word and count appear.
- seg_an and seg_out are registered. They update 1 cycle after idx changes or the buffer changes.
- One digit slot lasts SCAN_DIV cycles; a full frame lasts 8*SCAN_DIV.

## Configuration
- KEY_DISP_BLANK_EN defined: leading-zero blanking.
  - Digit i is enabled iff i < entry_count, or i==0 when entry_count==0 (shows "0").
- KEY_DISP_BLANK_EN undefined: all 8 digits are always enabled and unentered positions show 0.

## Test plan
Bench uses SCAN_DIV=4, SETTLE_CYC=3, with KEY_DISP_BLANK_EN both defined and undefined.
- Press 1, 2, 3 → entry_word=0x00000123, count=3, three strobes. Digit 0 shows F9... wait, digit 0 is the last key entered: digit 0 shows B0 (3), digit 1 A4 (2), digit 2 F9 (1). With blanking, digits 3..7 give seg_an=FF.
- Press 9 keys 1..9 → word=0x12345678, count=8, no strobe on the 9th press. Then 0xE → word=0x01234567, count=7.
- 0xE at count 0 → no strobe, word stays 0. Then 0xF → strobe, word 0, count 0; digit 0 shows C0.
- key_flag pulse shorter than the settle window (drops during SETTLE) → no change and no strobe. key_flag held for 1000 cycles → exactly one command.
- Assert rst during SETTLE → all outputs at reset values. Release rst with key_flag high → one capture follows.
- Free-run scan with count=8 → seg_an cycles FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.

Source files
------------

// File: rtl/key_entry_display.sv
// -----------------------------------------------------------------------------
// key_entry_display
//
// Consumes the 4x4 keypad scanner's key_flag/key_val pair and turns each press
// into one edit of an 8-digit hex entry buffer:
//   0x0..0xD  shift the digit in from the right (ignored when 8 digits held)
//   0xE       backspace (drop the rightmost digit)
//   0xF       clear
// It also drives an 8-digit multiplexed seven-segment display from the buffer.
//
// Build option:
//   KEY_DISP_BLANK_EN  when defined, unentered leading digits are blanked and
//                      digit 0 shows "0" while the buffer is empty. When not
//                      defined, all eight digits are always lit.
//
// Parameters:
//   SCAN_DIV    clk cycles per digit slot (2..2^20)
//   SETTLE_CYC  clk cycles from synchronized key_flag rise to key_val sample
//               (1..2^22)
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   key_flag      scanner key-pressed level (asynchronous to clk)
//   key_val[3:0]  scanner key code, quasi-static once settled
//   seg_an[7:0]   digit anodes, active-low, bit i = digit i (0 = rightmost)
//   seg_out[7:0]  segment cathodes, active-low, bit7 = dp, bits6..0 = g..a
//   entry_word    entry buffer, nibble i = digit i
//   entry_count   number of entered digits, 0..8
//   entry_strobe  one-cycle pulse, coincident with every buffer change
// -----------------------------------------------------------------------------
module key_entry_display #(
    parameter int SCAN_DIV   = 100000,
    parameter int SETTLE_CYC = 2097152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_flag,
    input  logic [3:0]  key_val,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out,
    output logic [31:0] entry_word,
    output logic [3:0]  entry_count,
    output logic        entry_strobe
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [SET_W-1:0] SETTLE_LD  = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EXEC,
        HOLD
    } state_t;

    // -------------------------------------------------------------------------
    // key_flag synchronizer and rising-edge detector
    // -------------------------------------------------------------------------
    logic flag_meta;
    logic flag_sync;
    logic flag_sync_d;
    logic flag_rise;

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample their inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_meta   <= 1'b0;
            flag_sync   <= 1'b0;
            flag_sync_d <= 1'b0;
        end else begin
            flag_meta   <= key_flag;
            flag_sync   <= flag_meta;
            flag_sync_d <= flag_sync;
        end
    end

    // Because the synchronizer resets to 0, a key still held across a reset
    // release shows up as a fresh rise and gets processed once.
    assign flag_rise = flag_sync & ~flag_sync_d;

    // -------------------------------------------------------------------------
    // Capture FSM
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_cnt_nxt;
    logic [3:0]       key_q;
    logic             key_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            key_q      <= 4'h0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (key_load) begin
                key_q <= key_val;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        key_load       = 1'b0;

        unique case (state)
            IDLE: begin
                if (flag_rise) begin
                    settle_cnt_nxt = SETTLE_LD;
                    state_nxt      = SETTLE;
                end
            end

            SETTLE: begin
                // A flag that drops before the window closes was a glitch or
                // an aborted press: abandon it without touching the buffer.
                if (!flag_sync) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == '0) begin
                    // key_val is quasi-static by now, so it is sampled
                    // directly rather than through a synchronizer.
                    key_load  = 1'b1;
                    state_nxt = EXEC;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end

            EXEC: begin
                state_nxt = HOLD;
            end

            HOLD: begin
                // Wait for release so a held key never auto-repeats.
                if (!flag_sync) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Entry buffer: command execution
    // -------------------------------------------------------------------------
    logic [31:0] word_nxt;
    logic [3:0]  count_nxt;
    logic        strobe_nxt;

    always_comb begin
        word_nxt   = entry_word;
        count_nxt  = entry_count;
        strobe_nxt = 1'b0;

        if (state == EXEC) begin
            if (key_q == 4'hF) begin
                // Clear always reports, even on an already empty buffer.
                word_nxt   = 32'h0;
                count_nxt  = 4'd0;
                strobe_nxt = 1'b1;
            end else if (key_q == 4'hE) begin
                if (entry_count != 4'd0) begin
                    word_nxt   = {4'h0, entry_word[31:4]};
                    count_nxt  = entry_count - 4'd1;
                    strobe_nxt = 1'b1;
                end
            end else begin
                if (entry_count < 4'd8) begin
                    word_nxt   = {entry_word[27:0], key_q};
                    count_nxt  = entry_count + 4'd1;
                    strobe_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_word   <= 32'h0;
            entry_count  <= 4'd0;
            entry_strobe <= 1'b0;
        end else begin
            entry_word   <= word_nxt;
            entry_count  <= count_nxt;
            entry_strobe <= strobe_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Display scan: slot divider and digit index
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;   // 3-bit wrap gives 7 -> 0
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Glyph lookup and digit enable
    // -------------------------------------------------------------------------
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    logic       digit_en;
    logic [3:0] digit_nib;

`ifdef KEY_DISP_BLANK_EN
    // Light only entered digits; an empty buffer still shows a single "0".
    assign digit_en = ({1'b0, idx} < entry_count) ||
                      ((idx == 3'd0) && (entry_count == 4'd0));
`else
    assign digit_en = 1'b1;
`endif

    assign digit_nib = entry_word[{idx, 2'b00} +: 4];

    // Registered outputs: a new idx or buffer value appears one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_an  <= 8'hFF;
            seg_out <= 8'hFF;
        end else if (digit_en) begin
            seg_an  <= ~(8'b1 << idx);
            seg_out <= glyph(digit_nib);
        end else begin
            seg_an  <= 8'hFF;
            seg_out <= 8'hFF;
        end
    end

endmodule
